mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024; number of 32-bit words stored (power of two).
REQ-002 SHALL have parameter LATENCY, default 4; cycles from request acceptance to response (legal 1..15).
REQ-003 SHALL have port i_clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous assert and active-low.
REQ-005 SHALL have port o_mem_ready  output  1  high when a new request is accepted on the next edge.
REQ-006 SHALL have port i_mem_addr  input  32  byte address; bits [1:0] ignored.
REQ-007 SHALL have port i_mem_ren  input  1  read request.
REQ-008 SHALL have port i_mem_wen  input  1  write request.
REQ-009 SHALL have port i_mem_wdata  input  32  full-word write data.
REQ-010 SHALL have port o_mem_rdata  output  32  read data, meaningful only while o_mem_valid high.
REQ-011 SHALL have port o_mem_valid  output  1  one-cycle response pulse.
REQ-012 SHALL have port o_proto_err  output  1  sticky protocol-violation flag.

Function
REQ-013 SHALL implement states IDLE, BUSY; IDLE -> BUSY on acceptance; BUSY -> IDLE when the latency counter expires.
REQ-014 SHALL accept a request at an edge where o_mem_ready=1 and (i_mem_ren or i_mem_wen)=1, latching address, data and kind.
REQ-015 SHALL ignore ren/wen sampled while o_mem_ready=0 (no effect on state or array).
REQ-016 SHALL drive o_mem_ready=0 from the acceptance edge until the response cycle.
REQ-017 SHALL assert o_mem_valid for exactly one cycle, starting LATENCY edges after the acceptance edge (LATENCY=1: the cycle immediately following acceptance).
REQ-018 SHALL drive o_mem_ready=1 in the same cycle o_mem_valid=1, so back-to-back requests give one response per LATENCY cycles.
REQ-019 SHALL, for a read, present mem[addr[ADDR_W+1:2]] on o_mem_rdata during the valid cycle, ADDR_W=log2(DEPTH_WORDS).
REQ-020 SHALL drive o_mem_rdata=0 whenever o_mem_valid=0.
REQ-021 SHALL wrap addresses: upper bits above ADDR_W+1 ignored, so address DEPTH_WORDS*4 aliases word 0.
REQ-022 SHALL, on simultaneous ren and wen at acceptance, perform the write only and set o_proto_err.
REQ-023 SHALL return a read issued after a write to the same word with the written data (no stale read).

Reset
REQ-024 SHALL, while i_rst_n=0, force state IDLE, o_mem_ready=0, o_mem_valid=0, o_mem_rdata=0, o_proto_err=0, counter=0, independent of i_clk.
REQ-025 SHALL raise o_mem_ready at the first rising edge after i_rst_n deasserts.
REQ-026 SHALL abort any in-flight request on reset: no valid pulse, and a pending write is not committed unless already committed per REQ-028/029.
REQ-027 SHALL leave memory-array contents unaffected by reset.

Configuration
REQ-028 SHALL, with macro MEM_RESPONDER_WRITE_ACK_EN defined, commit a write to the array in its response cycle and pulse o_mem_valid for it like a read (o_mem_rdata=0).
REQ-029 SHALL, without MEM_RESPONDER_WRITE_ACK_EN, commit a write at the acceptance edge, produce no o_mem_valid pulse, and keep o_mem_ready=1 (no BUSY entry).

Verification
REQ-030 SHALL cover: reset release, LATENCY=4, write 0xDEADBEEF to 0x40 then read 0x40 -> valid exactly 4 cycles after read acceptance, rdata=0xDEADBEEF.
REQ-031 SHALL cover: LATENCY=1, four back-to-back reads of 0x100,0x104,0x108,0x10C issued each ready cycle -> four valid pulses on consecutive cycles, correct data in order.
REQ-032 SHALL cover: ren held high during BUSY with changing address 0x200 -> ignored, only the accepted 0x100 read responds.
REQ-033 SHALL cover: ren=wen=1 at 0x8 with wdata 0x12345678 -> o_proto_err=1 stays high, subsequent read of 0x8 returns 0x12345678.
REQ-034 SHALL cover: i_rst_n pulsed low mid-BUSY between clock edges -> outputs zero immediately, no valid pulse, ready=1 one edge after release.
REQ-035 SHALL cover: DEPTH_WORDS=1024, write 0xA5A5A5A5 to 0x1000 -> read of 0x0 returns 0xA5A5A5A5; run both with and without MEM_RESPONDER_WRITE_ACK_EN.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory behind a fixed-latency ready/valid request port.
// Define MEM_RESPONDER_WRITE_ACK_EN to defer write commits to an acknowledged response cycle.
//
// state | meaning
// IDLE  | waiting for a request
// BUSY  | request accepted, latency counter running down to the response cycle
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_mem_ready,
    input  logic [31:0] i_mem_addr,
    input  logic        i_mem_ren,
    input  logic        i_mem_wen,
    input  logic [31:0] i_mem_wdata,
    output logic [31:0] o_mem_rdata,
    output logic        o_mem_valid,
    output logic        o_proto_err
);
    localparam int         ADDR_W   = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              live_q;
    logic              proto_err_q;
    logic [ADDR_W-1:0] word_q;
    logic [ADDR_W-1:0] word_in;
    logic              resp;
    logic              rd_resp;
    logic              accept;
    logic              start_busy;
    logic              unused_addr_bits;
    logic [31:0]       mem [DEPTH_WORDS];

    assign word_in          = i_mem_addr[ADDR_W+1:2];
    assign unused_addr_bits = &{1'b0, i_mem_addr[31:ADDR_W+2], i_mem_addr[1:0]};

    // live_q holds ready low until the first edge after reset release
    assign resp        = (state_q == BUSY) && (cnt_q == '0);
    assign o_mem_ready = live_q && ((state_q == IDLE) || resp);
    assign accept      = o_mem_ready && (i_mem_ren || i_mem_wen);
    assign o_mem_valid = resp;
    assign o_mem_rdata = rd_resp ? mem[word_q] : '0;
    assign o_proto_err = proto_err_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            live_q      <= 1'b0;
            proto_err_q <= 1'b0;
            word_q      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            live_q  <= 1'b1;
            if (accept) begin
                word_q <= word_in;
                if (i_mem_ren && i_mem_wen) begin
                    proto_err_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == BUSY) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                state_d = IDLE;
            end
        end
        // a new request may be accepted in the response cycle itself
        if (accept && start_busy) begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
        end
    end

`ifdef MEM_RESPONDER_WRITE_ACK_EN
    logic        write_q;
    logic [31:0] wdata_q;

    assign start_busy = 1'b1;
    assign rd_resp    = resp && !write_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            write_q <= 1'b0;
            wdata_q <= '0;
        end else if (accept) begin
            write_q <= i_mem_wen;
            wdata_q <= i_mem_wdata;
        end
    end

    // commit only at the end of the acknowledged cycle, so a reset mid-flight drops the write
    always_ff @(posedge i_clk) begin
        if (resp && write_q) begin
            mem[word_q] <= wdata_q;
        end
    end
`else
    assign start_busy = !i_mem_wen;
    assign rd_resp    = resp;

    always_ff @(posedge i_clk) begin
        if (accept && i_mem_wen) begin
            mem[word_in] <= i_mem_wdata;
        end
    end
`endif

endmodule
